// File: rtl/burst_ram_responder_pkg.sv
// Shared definitions for the burst RAM responder and its requesters:
// FSM state encoding, command values and a small elaboration helper.
package burst_ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    READ_DATA = 2'd3
  } burst_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port byte-masked RAM with a registered read port; the read
// register only updates on a read strobe, so it holds its last beat.
module burst_ram_array #(
  parameter int DEPTH_BITWIDTH = 8,
  parameter int DATA_BITWIDTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       re,
  input  logic [DEPTH_BITWIDTH-1:0]  addr,
  input  logic [DATA_BITWIDTH-1:0]   wdata,
  input  logic [DATA_BITWIDTH/8-1:0] wmask,
  output logic [DATA_BITWIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_BITWIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset; a set mask bit keeps the byte.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!wmask[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Burst responder: accepts one read/write burst command at a time and
// sequences beat addresses into the single-port RAM array.
module burst_ram_responder
  import burst_ram_responder_pkg::*;
#(
  parameter int DEPTH_BITWIDTH   = 8,
  parameter int DATA_BITWIDTH    = 64,
  parameter int BURST_DATA_COUNT = 4,
  parameter int READ_LATENCY     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       br_cmd,
  input  logic                       br_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]  br_addr,
  input  logic [DATA_BITWIDTH-1:0]   br_wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] br_data_mask,
  output logic [DATA_BITWIDTH-1:0]   br_rd_data,
  output logic                       br_rd_data_valid,
  output logic                       br_busy
);

  localparam int CNT_W = $clog2(max_int(READ_LATENCY, BURST_DATA_COUNT) + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] LAST_WRITE = CNT_W'(BURST_DATA_COUNT - 1);
  localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(BURST_DATA_COUNT);

  burst_state_e              state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [DEPTH_BITWIDTH-1:0] addr_q;
  logic                      rd_valid_q;
  logic                      accept;
  logic                      mem_we, mem_re;
  logic [CNT_W-1:0]          beat_off;
  logic [DEPTH_BITWIDTH-1:0] mem_addr;

  assign accept = br_cmd_en && (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rd_valid_q <= mem_re;
      if (accept) begin
        addr_q <= br_addr;
      end
    end
  end

  // cnt is the beat index in WRITE/READ_DATA and the elapsed-cycle count in READ_WAIT.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next = CNT_W'(1);
          if (br_cmd == CMD_WRITE) begin
            state_next = WRITE;
          end else if (READ_LATENCY == 1) begin
            state_next = READ_DATA;
          end else begin
            state_next = READ_WAIT;
          end
        end
      end
      WRITE: begin
        if (cnt == LAST_WRITE) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      READ_WAIT: begin
        if (cnt == LAST_WAIT) begin
          state_next = READ_DATA;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      READ_DATA: begin
        if (cnt == LAST_READ) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Each read beat is fetched one cycle before it must appear on br_rd_data.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    beat_off = cnt;
    case (state)
      IDLE: begin
        beat_off = '0;
        if (accept) begin
          mem_we = (br_cmd == CMD_WRITE);
          mem_re = (br_cmd == CMD_READ) && (READ_LATENCY == 1);
        end
      end
      WRITE: begin
        mem_we = 1'b1;
      end
      READ_WAIT: begin
        if (cnt == LAST_WAIT) begin
          mem_re   = 1'b1;
          beat_off = '0;
        end
      end
      READ_DATA: begin
        mem_re = (cnt != LAST_READ);
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign mem_addr = ((state == IDLE) ? br_addr : addr_q) + DEPTH_BITWIDTH'(beat_off);

  assign br_busy          = (state != IDLE);
  assign br_rd_data_valid = rd_valid_q;

  burst_ram_array #(
    .DEPTH_BITWIDTH (DEPTH_BITWIDTH),
    .DATA_BITWIDTH  (DATA_BITWIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (br_wr_data),
    .wmask (br_data_mask),
    .rdata (br_rd_data)
  );

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed plus randomized bench for burst_ram_responder, checked against
// a transaction-level memory model held in a plain array.
module tb_burst_ram_responder;
  import burst_ram_responder_pkg::*;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int B  = 4;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_cmd;
  logic          br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [MW-1:0] br_data_mask;
  logic [DW-1:0] br_rd_data;
  logic          br_rd_data_valid;
  logic          br_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [1 << AW];
  logic [DW-1:0] wr_beats [B];
  logic [MW-1:0] wr_masks [B];
  logic [DW-1:0] last_beat;
  logic [DW-1:0] first_obs;
  logic [AW-1:0] rnd_addr;

  always #5 clk = ~clk;

  burst_ram_responder #(
    .DEPTH_BITWIDTH   (AW),
    .DATA_BITWIDTH    (DW),
    .BURST_DATA_COUNT (B),
    .READ_LATENCY     (L)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cmd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [MW-1:0] mask);
    br_cmd_en    = en;
    br_cmd       = cmd;
    br_addr      = addr;
    br_wr_data   = data;
    br_data_mask = mask;
  endtask

  function automatic logic [DW-1:0] mergeBeat(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < MW; b++) begin
      if (!mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Issue a write burst from wr_beats/wr_masks; beats_done < B aborts with reset.
  task automatic writeBurst(input logic [AW-1:0] addr, input int beats_done);
    for (int k = 0; k < B; k++) begin
      @(negedge clk);
      checkOutput($sformatf("wr_busy_%0h_c%0d", addr, k), DW'(br_busy), DW'(k != 0));
      applyStimulus(k == 0, CMD_WRITE, (k == 0) ? addr : AW'($urandom), wr_beats[k], wr_masks[k]);
      if (k == beats_done) begin
        #1 rst = 1'b0;
        #1 checkOutput("wr_abort_busy", DW'(br_busy), DW'(0));
        @(negedge clk);
        rst = 1'b1;
        break;
      end
    end
    for (int k = 0; k < B; k++) begin
      if (k < beats_done) begin
        model[AW'(addr + k)] = mergeBeat(model[AW'(addr + k)], wr_beats[k], wr_masks[k]);
      end
    end
  endtask

  // Issue a read burst; inject drives ignored write strobes at C0+1..C0+3.
  task automatic readBurst(input logic [AW-1:0] addr, input bit inject,
                           output logic [DW-1:0] first_seen);
    logic [DW-1:0] exp_beats [B];
    first_seen = '0;
    for (int k = 0; k < B; k++) exp_beats[k] = model[AW'(addr + k)];
    for (int t = 0; t < L + B; t++) begin
      @(negedge clk);
      checkOutput($sformatf("rd_busy_%0h_c%0d", addr, t), DW'(br_busy), DW'(t != 0));
      checkOutput($sformatf("rd_valid_%0h_c%0d", addr, t), DW'(br_rd_data_valid), DW'(t >= L));
      if (t >= L) begin
        checkOutput($sformatf("rd_data_%0h_b%0d", addr, t - L), br_rd_data, exp_beats[t - L]);
        if (t == L) first_seen = br_rd_data;
      end
      if (t == 0)
        applyStimulus(1'b1, CMD_READ, addr, '0, '0);
      else if (inject && t <= 3)
        applyStimulus(1'b1, CMD_WRITE, addr, {$urandom, $urandom}, '0);
      else
        applyStimulus(1'b0, CMD_READ, '0, '0, '0);
    end
    last_beat = exp_beats[B-1];
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", DW'(br_busy), DW'(0));
      checkOutput("idle_valid", DW'(br_rd_data_valid), DW'(0));
      checkOutput("idle_hold", br_rd_data, last_beat);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, CMD_READ, '0, '0, '0);
    last_beat = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", DW'(br_busy), DW'(0));
    checkOutput("reset_valid", DW'(br_rd_data_valid), DW'(0));
    checkOutput("reset_data", br_rd_data, '0);
    rst = 1'b1;

    // Pattern burst at 0x10, read back in the cycle busy falls.
    for (int k = 0; k < B; k++) begin
      wr_beats[k] = {8{8'((k + 1) * 17)}};
      wr_masks[k] = '0;
    end
    writeBurst(8'h10, B);
    readBurst(8'h10, 1'b0, first_obs);
    idleCheck(2);

    // Wrapping burst at 0xFE, then two reads back to back.
    for (int k = 0; k < B; k++) begin
      wr_beats[k] = {$urandom, $urandom};
      wr_masks[k] = '0;
    end
    writeBurst(8'hFE, B);
    readBurst(8'hFE, 1'b0, first_obs);
    readBurst(8'h10, 1'b0, first_obs);
    idleCheck(1);

    // Byte-masked overwrite keeps the upper four bytes.
    for (int k = 0; k < B; k++) begin
      wr_beats[k] = '1;
      wr_masks[k] = 8'hF0;
    end
    writeBurst(8'h10, B);
    readBurst(8'h10, 1'b0, first_obs);
    checkOutput("mask_beat0_literal", first_obs, 64'h1111_1111_FFFF_FFFF);

    // Write strobes during an active read are ignored.
    readBurst(8'h10, 1'b1, first_obs);
    readBurst(8'h10, 1'b0, first_obs);
    idleCheck(1);

    // Reset in C0+5 of a read clears outputs before the next edge.
    @(negedge clk);
    applyStimulus(1'b1, CMD_READ, 8'hFE, '0, '0);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      applyStimulus(1'b0, CMD_READ, '0, '0, '0);
    end
    checkOutput("rst_pre_valid", DW'(br_rd_data_valid), DW'(1));
    checkOutput("rst_pre_data", br_rd_data, model[8'hFF]);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async_busy", DW'(br_busy), DW'(0));
    checkOutput("rst_async_valid", DW'(br_rd_data_valid), DW'(0));
    checkOutput("rst_async_data", br_rd_data, '0);
    @(negedge clk);
    rst = 1'b1;
    last_beat = '0;
    idleCheck(2);
    readBurst(8'hFE, 1'b0, first_obs);

    // Reset during a write keeps beats 0..1 and drops beats 2..3.
    for (int k = 0; k < B; k++) begin
      wr_beats[k] = {$urandom, $urandom};
      wr_masks[k] = '0;
    end
    writeBurst(8'h40, B);
    for (int k = 0; k < B; k++) wr_beats[k] = {$urandom, $urandom};
    writeBurst(8'h40, 2);
    readBurst(8'h40, 1'b0, first_obs);

    // Randomized full writes, masked overwrites and read-backs.
    for (int i = 0; i < 6; i++) begin
      rnd_addr = AW'($urandom);
      for (int k = 0; k < B; k++) begin
        wr_beats[k] = {$urandom, $urandom};
        wr_masks[k] = '0;
      end
      writeBurst(rnd_addr, B);
      for (int k = 0; k < B; k++) begin
        wr_beats[k] = {$urandom, $urandom};
        wr_masks[k] = MW'($urandom);
      end
      writeBurst(rnd_addr, B);
      readBurst(rnd_addr, ($urandom_range(0, 1) == 1), first_obs);
      if ($urandom_range(0, 1) == 1) idleCheck(1);
    end
    readBurst(8'h10, 1'b0, first_obs);
    readBurst(8'hFE, 1'b0, first_obs);
    idleCheck(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
BURST_RAM_RESPONDER -- requirements
Module: burst_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_BITWIDTH, default 8, beat-address width (memory holds 2^DEPTH_BITWIDTH beats).
REQ-002 SHALL have parameter DATA_BITWIDTH, default 64, beat width in bits (multiple of 8).
REQ-003 SHALL have parameter BURST_DATA_COUNT, default 4, beats per burst (>=2).
REQ-004 SHALL have parameter READ_LATENCY, default 4, cycles from read accept to first valid beat (>=1).
REQ-005 SHALL have port clk, in, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port br_cmd, in, 1: 0 = read, 1 = write.
REQ-008 SHALL have port br_cmd_en, in, 1: command strobe.
REQ-009 SHALL have port br_addr, in, DEPTH_BITWIDTH: burst start beat address.
REQ-010 SHALL have port br_wr_data, in, DATA_BITWIDTH: write beat data.
REQ-011 SHALL have port br_data_mask, in, DATA_BITWIDTH/8: bit i = 1 masks byte i (byte not written).
REQ-012 SHALL have port br_rd_data, out, DATA_BITWIDTH: read beat data.
REQ-013 SHALL have port br_rd_data_valid, out, 1: br_rd_data holds a valid beat.
REQ-014 SHALL have port br_busy, out, 1: command in progress; br_cmd_en ignored.

Function
REQ-015 SHALL accept a command in cycle C0 when br_cmd_en=1 and br_busy=0; br_cmd_en while br_busy=1 SHALL be ignored with no side effect.
REQ-016 SHALL latch br_cmd and br_addr at accept and assert br_busy from C0+1.
REQ-017 SHALL use FSM states IDLE, WRITE, READ_WAIT, READ_DATA; IDLE->WRITE or IDLE->READ_WAIT on accept.
REQ-018 On write, SHALL sample beat k (k=0..BURST_DATA_COUNT-1) in cycle C0+k and store it at (addr+k) mod 2^DEPTH_BITWIDTH; beat 0 is sampled in the accept cycle.
REQ-019 SHALL store only bytes whose br_data_mask bit is 0; masked bytes keep prior contents.
REQ-020 On write, SHALL deassert br_busy in cycle C0+BURST_DATA_COUNT (WRITE->IDLE); a new command is acceptable in that cycle.
REQ-021 On read, SHALL drive br_rd_data_valid=1 in cycles C0+READ_LATENCY .. C0+READ_LATENCY+BURST_DATA_COUNT-1, contiguous, with beat k = mem[(addr+k) mod 2^DEPTH_BITWIDTH].
REQ-022 SHALL transition READ_WAIT->READ_DATA so first valid beat appears exactly at C0+READ_LATENCY, then READ_DATA->IDLE after the last beat.
REQ-023 On read, SHALL deassert br_busy in cycle C0+READ_LATENCY+BURST_DATA_COUNT.
REQ-024 Beat address SHALL wrap modulo 2^DEPTH_BITWIDTH without error.
REQ-025 br_rd_data SHALL be registered and hold its last value when br_rd_data_valid=0.
REQ-026 Read data SHALL reflect all writes whose bursts completed before the read was accepted.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, beat counter 0, br_busy=0, br_rd_data_valid=0, br_rd_data=0.
REQ-028 Reset mid-burst SHALL abort the burst; beats already written stay written; no further beats written or returned.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 SHALL place FSM state encoding and br_cmd values (CMD_READ=0, CMD_WRITE=1) in a shared package used with the requester side.
REQ-031 SHALL instantiate one sub-module, burst_ram_array: single-port, byte-masked, registered-read memory of 2^DEPTH_BITWIDTH x DATA_BITWIDTH.

Verification
REQ-032 Write burst addr=0x10, beats 0x11..11,0x22..22,0x33..33,0x44..44, mask 0 -> busy high 4 cycles; read addr=0x10 -> valid at C0+4..C0+7 with same beats.
REQ-033 Write addr=0xFE, 4 beats -> read addr=0xFE returns beats at 0xFE,0xFF,0x00,0x01 (wrap).
REQ-034 Overwrite beat 0x10 with 0xFFFF_FFFF_FFFF_FFFF, mask 0xF0 -> read returns 0x1111_1111_FFFF_FFFF.
REQ-035 br_cmd_en=1 write at C0+1..C0+3 of active read -> ignored; memory unchanged, read beats intact.
REQ-036 rst=0 at C0+5 of read -> br_busy=0, br_rd_data_valid=0 immediately (asynchronously, before the next clock edge); next command accepted after release.
REQ-037 Back-to-back: read accepted in cycle busy falls -> valid exactly READ_LATENCY later.
